// File: rtl/fifo_tx_serializer_if.sv
// rtl/fifo_tx_serializer_if.sv - FIFO-side and serial-line signals of the tx serializer
interface fifo_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pop;
    logic              tx;
    logic              busy;
    logic              byte_done;

    // Serializer side
    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop,
        output tx,
        output busy,
        output byte_done
    );

    // FIFO / line consumer side
    modport slave (
        output enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_pop,
        input  tx,
        input  busy,
        input  byte_done
    );
endinterface

// File: rtl/fifo_tx_serializer.sv
// rtl/fifo_tx_serializer.sv - pops FIFO bytes and sends them as LSB-first async frames; optional parity via SER_PARITY_EN
module fifo_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic                  clk,
    input logic                  SER_reset,
    fifo_tx_serializer_if.master bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);

`ifdef SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
`ifdef SER_PARITY_EN
    logic              parity_acc;
`endif

    logic baud_last;
    logic stop_pre_last;
    logic bit_last;
    logic start_ok;

    assign baud_last     = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign stop_pre_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 2));
    assign bit_last      = (bit_cnt == BIT_W'(DATA_W - 1));
    assign start_ok      = bus.enable && !bus.fifo_empty;

    // Frame sequencer; every output is registered so tx/pop/busy/byte_done are glitch-free
    always_ff @(posedge clk or posedge SER_reset) begin
        if (SER_reset) begin
            state         <= IDLE;
            bus.tx        <= 1'b1;
            bus.fifo_pop  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.byte_done <= 1'b0;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
`ifdef SER_PARITY_EN
            parity_acc    <= 1'b0;
`endif
        end else begin
            bus.fifo_pop  <= 1'b0;
            bus.byte_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state        <= POP;
                        bus.fifo_pop <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                POP: begin
                    // FIFO presents the popped byte during the following cycle
                    state <= LOAD;
                end
                LOAD: begin
                    shreg    <= bus.fifo_data;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
`ifdef SER_PARITY_EN
                    parity_acc <= 1'b0;
`endif
                    state    <= START;
                    bus.tx   <= 1'b0;
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        bus.tx   <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
`ifdef SER_PARITY_EN
                        parity_acc <= parity_acc ^ shreg[0];
`endif
                        if (bit_last) begin
                            bit_cnt <= '0;
`ifdef SER_PARITY_EN
                            state  <= PARITY;
                            bus.tx <= parity_acc ^ shreg[0];
`else
                            state  <= STOP;
                            bus.tx <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // Next bit is the one about to land in bit 0 after the shift
                            bus.tx  <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        bus.tx   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the last stop cycle
                    if (stop_pre_last) begin
                        bus.byte_done <= 1'b1;
                    end
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (start_ok) begin
                            state        <= POP;
                            bus.fifo_pop <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb/tb_fifo_tx_serializer.sv - self-checking bench for fifo_tx_serializer
module tb_fifo_tx_serializer;
    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef SER_PARITY_EN
    localparam int NB = DATA_W + 3;
`else
    localparam int NB = DATA_W + 2;
`endif
    localparam int LAST = 2 + NB * CPB;

    logic clk = 1'b0;
    logic SER_reset = 1'b1;
    always #5 clk = ~clk;

    fifo_tx_serializer_if #(.DATA_W(DATA_W)) bus ();

    fifo_tx_serializer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .SER_reset (SER_reset),
        .bus       (bus)
    );

    // Simple upstream FIFO: stimulus writes mem/wp, the pop strobe advances rp
    logic [7:0] mem [0:15];
    int wp = 0;
    int rp = 0;
    assign bus.fifo_empty = (wp == rp);

    // Upstream FIFO read port: data appears the cycle after pop
    always @(posedge clk) begin
        if (bus.fifo_pop) begin
            bus.fifo_data <= mem[rp % 16];
            rp <= rp + 1;
        end
    end

    // Reference: k counts cycles since the frame's pop (1=pop, 2=load, 3.. line bits)
    int         m_k = -1;
    int         m_rp = 0;
    logic [7:0] m_byte = 8'h00;

    // Reference sequencer
    always @(posedge clk or posedge SER_reset) begin
        if (SER_reset) begin
            m_k = -1;
        end else begin
            if (m_k == -1 || m_k == LAST)
                m_k = (bus.enable && !bus.fifo_empty) ? 1 : -1;
            else
                m_k = m_k + 1;
            if (m_k == 1) begin
                m_byte = mem[m_rp % 16];
                m_rp++;
            end
        end
    end

    function automatic logic exp_tx(input int k, input logic [7:0] b);
        logic [NB-1:0] frame;
`ifdef SER_PARITY_EN
        frame = {1'b1, ^b, b, 1'b0};
`else
        frame = {1'b1, b, 1'b0};
`endif
        if (k < 3) return 1'b1;
        return frame[(k - 3) / CPB];
    endfunction

    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int busy_rise = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp % 16] = b;
        wp = wp + 1;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            tick();
            n++;
        end
        check({name, "_done_reached"}, int'(done_cnt >= target), 1);
        n = 0;
        while (bus.busy && n < 400) begin
            tick();
            n++;
        end
        check({name, "_idle_reached"}, int'(bus.busy), 0);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!(bus.busy && !bus.tx) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_start_seen"}, int'(bus.busy && !bus.tx), 1);
    endtask

    task automatic capture(output logic [NB-1:0] bits);
        bits = '0;
        for (int i = 0; i < NB; i++) begin
            bits[i] = bus.tx;
            if (i != NB - 1) repeat (CPB) tick();
        end
    endtask

    logic [NB-1:0] seq;
    int p0, d0, b0, r0;

    initial begin
        bus.enable = 1'b0;
        fork
            // Per-cycle compare against the reference, plus event counters
            forever begin
                @(negedge clk);
                check("tx", bus.tx, exp_tx(m_k, m_byte));
                check("fifo_pop", bus.fifo_pop, int'(m_k == 1));
                check("busy", bus.busy, int'(m_k >= 1));
                check("byte_done", bus.byte_done, int'(m_k == LAST));
                if (bus.fifo_pop) pop_cnt++;
                if (bus.byte_done) done_cnt++;
                if (bus.busy) busy_cnt++;
                if (bus.busy && !prev_busy) busy_rise++;
                prev_busy = bus.busy;
            end
            begin
                #200000;
                check("watchdog", 1, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join_none

        // Reset held with a non-empty FIFO
        push(8'h11);
        repeat (3) tick();
        check("rst_tx", bus.tx, 1);
        check("rst_pop", bus.fifo_pop, 0);
        check("rst_busy", bus.busy, 0);
        bus.enable = 1'b1;
        tick();
        check("rst_hold_pop", bus.fifo_pop, 0);
        SER_reset = 1'b0;
        tick();
        check("rel_pop_hi", bus.fifo_pop, 1);
        tick();
        check("rel_pop_lo", bus.fifo_pop, 0);
        wait_done(1, "first");

        // Single byte 0xA5
        p0 = pop_cnt; d0 = done_cnt; b0 = busy_cnt;
        push(8'hA5);
        wait_start("a5");
        capture(seq);
`ifdef SER_PARITY_EN
        check("a5_line", int'(seq), int'(11'b10101001010));
`else
        check("a5_line", int'(seq), int'(10'b1101001010));
`endif
        wait_done(d0 + 1, "a5");
        check("a5_pops", pop_cnt - p0, 1);
        check("a5_done", done_cnt - d0, 1);
`ifdef SER_PARITY_EN
        check("a5_busy_len", busy_cnt - b0, 46);
`else
        check("a5_busy_len", busy_cnt - b0, 42);
`endif

`ifdef SER_PARITY_EN
        // Odd payload weight gives parity bit 1
        d0 = done_cnt;
        push(8'h07);
        wait_start("p07");
        capture(seq);
        check("p07_parity", int'(seq[9]), 1);
        wait_done(d0 + 1, "p07");
`endif

        // Back-to-back 0x01, 0x02
        p0 = pop_cnt; d0 = done_cnt; b0 = busy_cnt; r0 = busy_rise;
        push(8'h01);
        push(8'h02);
        wait_done(d0 + 2, "b2b");
        check("b2b_pops", pop_cnt - p0, 2);
        check("b2b_busy_rises", busy_rise - r0, 1);
`ifdef SER_PARITY_EN
        check("b2b_busy_len", busy_cnt - b0, 92);
`else
        check("b2b_busy_len", busy_cnt - b0, 84);
`endif

        // Disable during data bit 3 of 0x3C with 0x5A still queued
        p0 = pop_cnt; d0 = done_cnt;
        push(8'h3C);
        push(8'h5A);
        wait_start("dis");
        repeat (4 * CPB + 1) tick();
        bus.enable = 1'b0;
        wait_done(d0 + 1, "dis");
        repeat (60) tick();
        check("dis_pops", pop_cnt - p0, 1);
        check("dis_done", done_cnt - d0, 1);
        check("dis_fifo_left", int'(bus.fifo_empty), 0);

        // Reset during DATA of 0x5A, then a fresh frame for 0x66
        p0 = pop_cnt; d0 = done_cnt;
        bus.enable = 1'b1;
        wait_start("mid");
        repeat (2 * CPB) tick();
        SER_reset = 1'b1;
        #1;
        check("mid_rst_tx", bus.tx, 1);
        check("mid_rst_busy", bus.busy, 0);
        tick();
        check("mid_rst_pop", bus.fifo_pop, 0);
        SER_reset = 1'b0;
        push(8'h66);
        wait_done(d0 + 1, "fresh");
        check("fresh_pops", pop_cnt - p0, 2);
        check("fresh_done", done_cnt - d0, 1);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
